vram_wr_arbiter: RTL and testbench

Shares the single write port of the R/G/B VRAM plane memories between two Ethernet RX byte-to-pixel converter channels. Each channel's plane writes (address, byte, plane enable) are buffered in a private FIFO. The FIFOs are then drained round-robin at one write per clock. The block sits between the converter outputs and the VRAM plane write ports, all in the dclk domain. It also reports overflow when a channel outruns the shared port.

---
 rtl/vram_wr_arbiter_pkg.sv | 25 ++
 rtl/vram_wr_arbiter_if.sv | 41 ++++
 rtl/vram_wr_arbiter_sync_fifo.sv | 49 ++++
 rtl/vram_wr_arbiter.sv | 124 ++++++++++++
 tb/tb_vram_wr_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_wr_arbiter_pkg.sv
// Shared constants and types for the VRAM write-port arbiter.
package vram_arb_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned WE_W   = 3;

  // Plane-enable bit positions within a stored we pattern
  localparam logic [WE_W-1:0] WE_R = 3'b001;
  localparam logic [WE_W-1:0] WE_G = 3'b010;
  localparam logic [WE_W-1:0] WE_B = 3'b100;

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W + WE_W;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } chan_e;

  // Stored entry layout is {addr, data, we}
  function automatic int unsigned entry_width(input int unsigned aw, input int unsigned dw);
    return aw + dw + WE_W;
  endfunction

endpackage

// File: rtl/vram_wr_arbiter_if.sv
// Converter-side channels and VRAM-side write port of the arbiter.
interface vram_wr_arbiter_if #(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0] ch0_addr;
  logic [DATA_W-1:0] ch0_data;
  logic [2:0]        ch0_we;
  logic [ADDR_W-1:0] ch1_addr;
  logic [DATA_W-1:0] ch1_data;
  logic [2:0]        ch1_we;
  logic              clr_ovf;

  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_data;
  logic              vram_wea_r;
  logic              vram_wea_g;
  logic              vram_wea_b;
  logic              grant;
  logic              ovf0;
  logic              ovf1;
  logic [7:0]        drop_cnt0;
  logic [7:0]        drop_cnt1;
  logic [LVL_W-1:0]  fifo_lvl0;
  logic [LVL_W-1:0]  fifo_lvl1;

  modport master (
    output ch0_addr, ch0_data, ch0_we, ch1_addr, ch1_data, ch1_we, clr_ovf,
    input  vram_addr, vram_data, vram_wea_r, vram_wea_g, vram_wea_b, grant,
           ovf0, ovf1, drop_cnt0, drop_cnt1, fifo_lvl0, fifo_lvl1
  );

  modport slave (
    input  ch0_addr, ch0_data, ch0_we, ch1_addr, ch1_data, ch1_we, clr_ovf,
    output vram_addr, vram_data, vram_wea_r, vram_wea_g, vram_wea_b, grant,
           ovf0, ovf1, drop_cnt0, drop_cnt1, fifo_lvl0, fifo_lvl1
  );
endinterface

// File: rtl/vram_wr_arbiter_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers so all DEPTH entries are usable.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer update; wraps modulo DEPTH with the MSB tracking lap parity
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are not cleared, pointers make them invisible
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Derived only from pointer flops, so it reflects the previous edge
  assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/vram_wr_arbiter.sv
// Two-channel round-robin arbiter for the shared VRAM plane write port.
module vram_wr_arbiter #(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input logic              dclk,
  input logic              rst,
  vram_wr_arbiter_if.slave bus
);
  import vram_arb_pkg::*;

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EW    = entry_width(ADDR_W, DATA_W);

  logic [EW-1:0]    head0, head1, head;
  logic [LVL_W-1:0] lvl0, lvl1;
  logic             full0, full1, empty0, empty1;
  logic             push0, push1, pop0, pop1, drop0, drop1;
  logic             pop_any;
  logic             req0, req1;
  chan_e            last, last_next, sel;
  logic [WE_W-1:0]  head_we;

  assign req0 = !rst && (bus.ch0_we != '0);
  assign req1 = !rst && (bus.ch1_we != '0);

  // A full FIFO still accepts when it is popped in the same cycle
  assign push0 = req0 && (!full0 || pop0);
  assign push1 = req1 && (!full1 || pop1);
  assign drop0 = req0 && full0 && !pop0;
  assign drop1 = req1 && full1 && !pop1;

  sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk(dclk), .rst(rst), .push(push0), .din({bus.ch0_addr, bus.ch0_data, bus.ch0_we}),
    .pop(pop0), .dout(head0), .full(full0), .empty(empty0), .level(lvl0)
  );

  sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(dclk), .rst(rst), .push(push1), .din({bus.ch1_addr, bus.ch1_data, bus.ch1_we}),
    .pop(pop1), .dout(head1), .full(full1), .empty(empty1), .level(lvl1)
  );

  // Most-recent-grant register; reset favours channel 0 on first contention
  always_ff @(posedge dclk) begin
    if (rst) last <= CH1;
    else     last <= last_next;
  end

  // Round-robin selection among non-empty FIFOs
  always_comb begin
    sel       = CH0;
    pop_any   = 1'b0;
    last_next = last;
    if (!empty0 && !empty1) begin
      sel     = (last == CH0) ? CH1 : CH0;
      pop_any = 1'b1;
    end else if (!empty0) begin
      sel     = CH0;
      pop_any = 1'b1;
    end else if (!empty1) begin
      sel     = CH1;
      pop_any = 1'b1;
    end
    if (pop_any) last_next = sel;
  end

  assign pop0    = pop_any && (sel == CH0);
  assign pop1    = pop_any && (sel == CH1);
  assign head    = (sel == CH1) ? head1 : head0;
  assign head_we = head[WE_W-1:0];

  // Registered write port; address/data/grant hold while idle
  always_ff @(posedge dclk) begin
    if (rst) begin
      bus.vram_addr  <= '0;
      bus.vram_data  <= '0;
      bus.vram_wea_r <= 1'b0;
      bus.vram_wea_g <= 1'b0;
      bus.vram_wea_b <= 1'b0;
      bus.grant      <= 1'b0;
    end else begin
      bus.vram_wea_r <= pop_any && ((head_we & WE_R) != '0);
      bus.vram_wea_g <= pop_any && ((head_we & WE_G) != '0);
      bus.vram_wea_b <= pop_any && ((head_we & WE_B) != '0);
      if (pop_any) begin
        bus.vram_addr <= head[WE_W+DATA_W +: ADDR_W];
        bus.vram_data <= head[WE_W +: DATA_W];
        bus.grant     <= sel;
      end
    end
  end

  // Overflow bookkeeping; a drop in the clear cycle leaves flag=1, count=1
  always_ff @(posedge dclk) begin
    if (rst) begin
      bus.ovf0      <= 1'b0;
      bus.ovf1      <= 1'b0;
      bus.drop_cnt0 <= '0;
      bus.drop_cnt1 <= '0;
    end else begin
      if (drop0) begin
        bus.ovf0 <= 1'b1;
        if (bus.clr_ovf)                bus.drop_cnt0 <= 8'd1;
        else if (bus.drop_cnt0 != '1)   bus.drop_cnt0 <= bus.drop_cnt0 + 8'd1;
      end else if (bus.clr_ovf) begin
        bus.ovf0      <= 1'b0;
        bus.drop_cnt0 <= '0;
      end
      if (drop1) begin
        bus.ovf1 <= 1'b1;
        if (bus.clr_ovf)                bus.drop_cnt1 <= 8'd1;
        else if (bus.drop_cnt1 != '1)   bus.drop_cnt1 <= bus.drop_cnt1 + 8'd1;
      end else if (bus.clr_ovf) begin
        bus.ovf1      <= 1'b0;
        bus.drop_cnt1 <= '0;
      end
    end
  end

  assign bus.fifo_lvl0 = lvl0;
  assign bus.fifo_lvl1 = lvl1;

endmodule

// File: tb/tb_vram_wr_arbiter.sv
// Self-checking bench for vram_wr_arbiter against a queue-based reference model.
module tb_vram_wr_arbiter;
  localparam int unsigned AW    = 24;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic dclk = 1'b0;
  logic rst  = 1'b1;
  always #5 dclk = ~dclk;

  vram_wr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

  vram_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .dclk(dclk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [2:0]    w;
  } ent_t;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: two queues, the last-granted channel, expected outputs
  ent_t          q0[$];
  ent_t          q1[$];
  bit            m_last;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [2:0]    e_we;
  logic          e_grant;
  logic          e_ovf0, e_ovf1;
  int            e_cnt0, e_cnt1;

  function automatic logic [63:0] dut_vec();
    return {bus.vram_addr, bus.vram_data, bus.vram_wea_b, bus.vram_wea_g, bus.vram_wea_r,
            bus.grant, bus.ovf0, bus.ovf1, bus.drop_cnt0, bus.drop_cnt1,
            bus.fifo_lvl0, bus.fifo_lvl1};
  endfunction

  function automatic logic [63:0] exp_vec();
    return {e_addr, e_data, e_we, e_grant, e_ovf0, e_ovf1, 8'(e_cnt0), 8'(e_cnt1),
            LW'(q0.size()), LW'(q1.size())};
  endfunction

  task automatic set_idle();
    bus.ch0_we = 3'b000; bus.ch0_addr = '0; bus.ch0_data = '0;
    bus.ch1_we = 3'b000; bus.ch1_addr = '0; bus.ch1_data = '0;
    bus.clr_ovf = 1'b0;
  endtask

  // One clock: drive inputs, advance the model by the stated rules, sample at +1
  task automatic step(input logic [2:0] w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic [2:0] w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic c);
    int s0, s1, sel;
    ent_t e;
    bus.ch0_we = w0; bus.ch0_addr = a0; bus.ch0_data = d0;
    bus.ch1_we = w1; bus.ch1_addr = a1; bus.ch1_data = d1;
    bus.clr_ovf = c;
    s0 = q0.size();
    s1 = q1.size();
    if (s0 > 0 && s1 > 0) sel = m_last ? 0 : 1;
    else if (s0 > 0)      sel = 0;
    else if (s1 > 0)      sel = 1;
    else                  sel = -1;
    e_we = 3'b000;
    if (sel == 0) begin
      e = q0.pop_front();
      e_addr = e.a; e_data = e.d; e_we = e.w; e_grant = 1'b0; m_last = 1'b0;
    end else if (sel == 1) begin
      e = q1.pop_front();
      e_addr = e.a; e_data = e.d; e_we = e.w; e_grant = 1'b1; m_last = 1'b1;
    end
    if (c) begin
      e_ovf0 = 1'b0; e_ovf1 = 1'b0; e_cnt0 = 0; e_cnt1 = 0;
    end
    if (w0 != 3'b000) begin
      if (s0 < DEPTH || sel == 0) q0.push_back({a0, d0, w0});
      else begin e_ovf0 = 1'b1; if (e_cnt0 < 255) e_cnt0++; end
    end
    if (w1 != 3'b000) begin
      if (s1 < DEPTH || sel == 1) q1.push_back({a1, d1, w1});
      else begin e_ovf1 = 1'b1; if (e_cnt1 < 255) e_cnt1++; end
    end
    @(posedge dclk);
    #1;
  endtask

  task automatic idle_step();
    step(3'b000, '0, '0, 3'b000, '0, '0, 1'b0);
  endtask

  task automatic both_step();
    step(3'($urandom_range(1, 7)), AW'($urandom), DW'($urandom),
         3'($urandom_range(1, 7)), AW'($urandom), DW'($urandom), 1'b0);
  endtask

  // Reset with pushing garbage on the inputs, which must be ignored
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    bus.ch0_we = 3'($urandom_range(1, 7)); bus.ch0_addr = AW'($urandom); bus.ch0_data = DW'($urandom);
    bus.ch1_we = 3'($urandom_range(1, 7)); bus.ch1_addr = AW'($urandom); bus.ch1_data = DW'($urandom);
    bus.clr_ovf = 1'b0;
    repeat (cycles) @(posedge dclk);
    #1;
    rst = 1'b0;
    set_idle();
    q0.delete(); q1.delete();
    m_last = 1'b1;
    e_addr = '0; e_data = '0; e_we = 3'b000; e_grant = 1'b0;
    e_ovf0 = 1'b0; e_ovf1 = 1'b0; e_cnt0 = 0; e_cnt1 = 0;
  endtask

  task automatic test_reset();
    do_reset(3);
    tests_run++;
    if (dut_vec() !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec(), 64'd0);
    end
    idle_step();
    tests_run++;
    if (dut_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL reset_no_write got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_single();
    do_reset(2);
    step(3'b001, 24'h000100, 8'hA5, 3'b000, '0, '0, 1'b0);
    tests_run++;
    if (dut_vec() !== exp_vec() || bus.fifo_lvl0 !== LW'(1)) begin
      tests_failed++;
      $display("FAIL single_push got=%h exp=%h", dut_vec(), exp_vec());
    end
    idle_step();
    tests_run++;
    if ({bus.vram_wea_b, bus.vram_wea_g, bus.vram_wea_r, bus.vram_addr, bus.vram_data, bus.grant}
        !== {3'b001, 24'h000100, 8'hA5, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_write got=%b/%h/%h/%b exp=001/000100/a5/0",
               {bus.vram_wea_b, bus.vram_wea_g, bus.vram_wea_r}, bus.vram_addr, bus.vram_data, bus.grant);
    end
    idle_step();
    tests_run++;
    if ({bus.vram_wea_b, bus.vram_wea_g, bus.vram_wea_r} !== 3'b000 || bus.vram_addr !== 24'h000100) begin
      tests_failed++;
      $display("FAIL single_after got=%b/%h exp=000/000100",
               {bus.vram_wea_b, bus.vram_wea_g, bus.vram_wea_r}, bus.vram_addr);
    end
  endtask

  task automatic test_contention();
    logic [AW-1:0] waddr[$];
    logic          wgnt[$];
    do_reset(2);
    for (int i = 0; i < 12; i++) begin
      if (i < 4) step(3'($urandom_range(1, 7)), AW'(32'h10 + i), DW'($urandom),
                      3'($urandom_range(1, 7)), AW'(32'h20 + i), DW'($urandom), 1'b0);
      else idle_step();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL contention_cycle%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if ({bus.vram_wea_b, bus.vram_wea_g, bus.vram_wea_r} != 3'b000) begin
        waddr.push_back(bus.vram_addr);
        wgnt.push_back(bus.grant);
      end
    end
    tests_run++;
    if (waddr.size() != 8) begin
      tests_failed++;
      $display("FAIL contention_count got=%0d exp=8", waddr.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        tests_run++;
        if (wgnt[k] !== 1'(k % 2) || waddr[k] !== AW'(((k % 2) != 0 ? 32'h20 : 32'h10) + k / 2)) begin
          tests_failed++;
          $display("FAIL contention_order%0d got=%b/%h exp=%b/%h", k, wgnt[k], waddr[k],
                   1'(k % 2), AW'(((k % 2) != 0 ? 32'h20 : 32'h10) + k / 2));
        end
      end
    end
    tests_run++;
    if (bus.ovf0 !== 1'b0 || bus.ovf1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL contention_ovf got=%b%b exp=00", bus.ovf0, bus.ovf1);
    end
  endtask

  task automatic test_overflow();
    int writes = 0;
    do_reset(2);
    for (int i = 0; i < 80; i++) begin
      if (i < 40) both_step();
      else idle_step();
      if ({bus.vram_wea_b, bus.vram_wea_g, bus.vram_wea_r} != 3'b000) writes++;
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL overflow_cycle%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    tests_run++;
    if (writes + int'(bus.drop_cnt0) + int'(bus.drop_cnt1) != 80 || (bus.ovf0 | bus.ovf1) !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_total got=%0d ovf=%b%b exp=80 ovf!=00",
               writes + int'(bus.drop_cnt0) + int'(bus.drop_cnt1), bus.ovf0, bus.ovf1);
    end
    step(3'b000, '0, '0, 3'b000, '0, '0, 1'b1);
    tests_run++;
    if ({bus.ovf0, bus.ovf1, bus.drop_cnt0, bus.drop_cnt1} !== 18'd0) begin
      tests_failed++;
      $display("FAIL overflow_clear got=%b%b/%0d/%0d exp=00/0/0",
               bus.ovf0, bus.ovf1, bus.drop_cnt0, bus.drop_cnt1);
    end
  endtask

  task automatic test_clr_race();
    int guard = 0;
    do_reset(2);
    while (!(q0.size() == DEPTH && q1.size() == DEPTH) && guard < 100) begin
      both_step();
      guard++;
    end
    tests_run++;
    if (guard >= 100) begin
      tests_failed++;
      $display("FAIL clr_race_fill got=timeout exp=both_full");
    end
    step(3'b001, AW'($urandom), DW'($urandom), 3'b001, AW'($urandom), DW'($urandom), 1'b1);
    tests_run++;
    if (dut_vec() !== exp_vec() || int'(bus.drop_cnt0) + int'(bus.drop_cnt1) != 1) begin
      tests_failed++;
      $display("FAIL clr_race got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_full_pop();
    int guard = 0;
    do_reset(2);
    while (!(q0.size() == DEPTH && m_last) && guard < 100) begin
      if (q0.size() < DEPTH) both_step();
      else step(3'b000, '0, '0, 3'b100, AW'($urandom), DW'($urandom), 1'b0);
      guard++;
    end
    tests_run++;
    if (guard >= 100 || bus.fifo_lvl0 !== LW'(DEPTH)) begin
      tests_failed++;
      $display("FAIL full_pop_fill got=%0d exp=%0d", bus.fifo_lvl0, DEPTH);
    end
    step(3'b010, 24'hABCDEF, 8'h3C, 3'b000, '0, '0, 1'b0);
    tests_run++;
    if (bus.fifo_lvl0 !== LW'(DEPTH) || bus.drop_cnt0 !== 8'd0 || bus.ovf0 !== 1'b0 || bus.grant !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_pop got=lvl%0d/cnt%0d/ovf%b/g%b exp=lvl%0d/cnt0/ovf0/g0",
               bus.fifo_lvl0, bus.drop_cnt0, bus.ovf0, bus.grant, DEPTH);
    end
    tests_run++;
    if (dut_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL full_pop_model got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    do_reset(2);
    while (!(q0.size() >= 5 && q1.size() >= 5) && guard < 40) begin
      both_step();
      guard++;
    end
    do_reset(1);
    tests_run++;
    if ({bus.vram_wea_b, bus.vram_wea_g, bus.vram_wea_r, bus.fifo_lvl0, bus.fifo_lvl1,
         bus.ovf0, bus.ovf1, bus.drop_cnt0, bus.drop_cnt1} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid got=%h exp=0", dut_vec());
    end
    both_step();
    idle_step();
    tests_run++;
    if (bus.grant !== 1'b0 || {bus.vram_wea_b, bus.vram_wea_g, bus.vram_wea_r} === 3'b000) begin
      tests_failed++;
      $display("FAIL reset_mid_grant got=%b exp=0", bus.grant);
    end
  endtask

  task automatic test_we_patterns();
    do_reset(2);
    step(3'b000, 24'h555555, 8'h77, 3'b000, '0, '0, 1'b0);
    tests_run++;
    if (bus.fifo_lvl0 !== LW'(0)) begin
      tests_failed++;
      $display("FAIL we_zero_level got=%0d exp=0", bus.fifo_lvl0);
    end
    step(3'b011, 24'h001234, 8'h5A, 3'b000, '0, '0, 1'b0);
    tests_run++;
    if ({bus.vram_wea_b, bus.vram_wea_g, bus.vram_wea_r} !== 3'b000) begin
      tests_failed++;
      $display("FAIL we_zero_write got=%b exp=000", {bus.vram_wea_b, bus.vram_wea_g, bus.vram_wea_r});
    end
    idle_step();
    tests_run++;
    if ({bus.vram_wea_b, bus.vram_wea_g, bus.vram_wea_r, bus.vram_addr, bus.vram_data}
        !== {3'b011, 24'h001234, 8'h5A}) begin
      tests_failed++;
      $display("FAIL we_multi got=%b/%h/%h exp=011/001234/5a",
               {bus.vram_wea_b, bus.vram_wea_g, bus.vram_wea_r}, bus.vram_addr, bus.vram_data);
    end
    idle_step();
    tests_run++;
    if ({bus.vram_wea_b, bus.vram_wea_g, bus.vram_wea_r} !== 3'b000) begin
      tests_failed++;
      $display("FAIL we_multi_once got=%b exp=000", {bus.vram_wea_b, bus.vram_wea_g, bus.vram_wea_r});
    end
  endtask

  task automatic test_random();
    int pct;
    do_reset(2);
    for (int i = 0; i < 500; i++) begin
      pct = (i >= 150 && i < 250) ? 90 : 45;
      step(($urandom_range(0, 99) < pct) ? 3'($urandom) : 3'b000, AW'($urandom), DW'($urandom),
           ($urandom_range(0, 99) < pct) ? 3'($urandom) : 3'b000, AW'($urandom), DW'($urandom),
           ($urandom_range(0, 29) == 0));
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random_cycle%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_single();
    test_contention();
    test_overflow();
    test_clr_race();
    test_full_pop();
    test_reset_mid();
    test_we_patterns();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
